// File: rtl/iterlm_seq_ctrl_if.sv
// Operand/result handshake bundle for the iterative logarithmic multiplier controller.
// The master side is the operand source and result consumer. The slave side is the controller.
`timescale 1ns/1ps
interface iterlm_seq_ctrl_if #(
    parameter int N    = 16,
    parameter int ITER = 2
);
    localparam int CW = $clog2(ITER + 1);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   p;
    logic [CW-1:0]    iters_used;
    logic             exact;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, iters_used, exact
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, iters_used, exact
    );
endinterface

// File: rtl/iterlm_seq_ctrl.sv
// Sequential IterLM controller: Mitchell-style correction iterations on one shared 2N-bit adder,
// with one add per cycle.
`timescale 1ns/1ps
module iterlm_seq_ctrl #(
    parameter int N    = 16,
    parameter int ITER = 2
) (
    input  logic               clk,
    input  logic               rst,
    iterlm_seq_ctrl_if.slave   bus
);
    localparam int W  = 2 * N;
    localparam int KW = $clog2(N);
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [2:0] {IDLE, LOD, ADD1, ADD2, ACC, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    r1_q, r2_q, x1_q, x2_q;
    logic [KW-1:0]   k1_q, k2_q;
    logic [W-1:0]    tmp_q, acc_q, p_q;
    logic [CW-1:0]   cnt_q, iters_q;
    logic            exact_q;

    logic            in_ready, out_valid, accept, any_zero, last_iter;
    logic [W-1:0]    add_a, add_b, sum;
    logic [KW-1:0]   lod1, lod2;
    logic [KW:0]     ksum;
    logic [CW-1:0]   cnt_inc;

    function automatic logic [KW-1:0] lod(input logic [N-1:0] v);
        lod = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) lod = KW'(i);
        end
    endfunction

    assign accept    = bus.in_valid && in_ready;
    assign any_zero  = (r1_q == '0) || (r2_q == '0);
    assign cnt_inc   = cnt_q + 1'b1;
    assign last_iter = (cnt_inc == CW'(ITER));
    assign lod1      = lod(r1_q);
    assign lod2      = lod(r2_q);
    assign ksum      = {1'b0, k1_q} + {1'b0, k2_q};
    assign sum       = add_a + add_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = LOD;
            LOD:  state_d = any_zero ? DONE : ADD1;
            ADD1: state_d = ADD2;
            ADD2: state_d = ACC;
            ACC:  state_d = last_iter ? DONE : LOD;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Adder operands are forced to zero outside the three add states.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            ADD1: begin
                add_a = W'(1) << ksum;
                add_b = W'(x1_q) << k2_q;
            end
            ADD2: begin
                add_a = tmp_q;
                add_b = W'(x2_q) << k1_q;
            end
            ACC: begin
                add_a = acc_q;
                add_b = tmp_q;
            end
            DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_q    <= '0;
            r2_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            tmp_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            iters_q <= '0;
            exact_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    r1_q  <= bus.a;
                    r2_q  <= bus.b;
                    acc_q <= '0;
                    cnt_q <= '0;
                end
                LOD: begin
                    if (any_zero) begin
                        p_q     <= acc_q;
                        iters_q <= cnt_q;
                        exact_q <= 1'b1;
                    end else begin
                        k1_q <= lod1;
                        k2_q <= lod2;
                        x1_q <= r1_q & ~(N'(1) << lod1);
                        x2_q <= r2_q & ~(N'(1) << lod2);
                    end
                end
                ADD1, ADD2: tmp_q <= sum;
                ACC: begin
                    acc_q <= sum;
                    r1_q  <= x1_q;
                    r2_q  <= x2_q;
                    cnt_q <= cnt_inc;
                    // Residues for the result flags are the post-update r1/r2, i.e. x1/x2.
                    if (last_iter) begin
                        p_q     <= sum;
                        iters_q <= cnt_inc;
                        exact_q <= (x1_q == '0) || (x2_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.p          = p_q;
    assign bus.iters_used = iters_q;
    assign bus.exact      = exact_q;
endmodule

// File: tb/tb_iterlm_seq_ctrl.sv
// Scoreboard bench for iterlm_seq_ctrl: an ITER=2 and an ITER=1 instance share clk/rst.
`timescale 1ns/1ps
module tb_iterlm_seq_ctrl;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iterlm_seq_ctrl_if #(.N(N), .ITER(2)) if2 ();
    iterlm_seq_ctrl_if #(.N(N), .ITER(1)) if1 ();

    iterlm_seq_ctrl #(.N(N), .ITER(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    iterlm_seq_ctrl #(.N(N), .ITER(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    typedef struct {
        logic [31:0] p;
        int          iters;
        logic        exact;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic drive(input int d, input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
        if (d == 1) begin if1.in_valid = v; if1.a = a; if1.b = b; end
        else        begin if2.in_valid = v; if2.a = a; if2.b = b; end
    endtask

    task automatic set_ready(input int d, input logic r);
        if (d == 1) if1.out_ready = r;
        else        if2.out_ready = r;
    endtask

    task automatic sample(input int d, output logic ov, output logic ir,
                          output logic [31:0] pv, output int it, output logic ex);
        if (d == 1) begin
            ov = if1.out_valid; ir = if1.in_ready; pv = if1.p; it = int'(if1.iters_used); ex = if1.exact;
        end else begin
            ov = if2.out_valid; ir = if2.in_ready; pv = if2.p; it = int'(if2.iters_used); ex = if2.exact;
        end
    endtask

    // Reference IterLM algorithm, written from the behavioural description.
    function automatic exp_t model(input int iter, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t        e;
        logic [31:0] acc;
        logic [N-1:0] r1, r2;
        int          k1, k2, j;
        bit          early;
        acc = 0; r1 = a; r2 = b; j = 0; early = 0;
        while (j < iter) begin
            if (r1 == 0 || r2 == 0) begin early = 1; break; end
            k1 = 0; k2 = 0;
            for (int i = 0; i < N; i++) begin
                if (r1[i]) k1 = i;
                if (r2[i]) k2 = i;
            end
            r1[k1] = 1'b0;
            r2[k2] = 1'b0;
            acc = acc + (32'd1 << (k1 + k2)) + (32'(r1) << k2) + (32'(r2) << k1);
            j++;
        end
        e.p = acc; e.iters = j; e.exact = (r1 == 0) || (r2 == 0);
        e.lat = early ? 4 * j + 1 : 4 * iter;
        return e;
    endfunction

    // Issues one operation, waits for the result and completes the handshake.
    task automatic run_op(input int d, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [31:0] pv, output int it, output logic ex,
                          output int lat, output bit to);
        logic ov, ir;
        @(negedge clk);
        drive(d, 1'b1, a, b);
        @(negedge clk);
        drive(d, 1'b0, '0, '0);
        lat = 0;
        sample(d, ov, ir, pv, it, ex);
        while (!ov && lat < 200) begin
            @(negedge clk);
            lat++;
            sample(d, ov, ir, pv, it, ex);
        end
        to = !ov;
        set_ready(d, 1'b1);
        @(negedge clk);
        set_ready(d, 1'b0);
    endtask

    task automatic test_reset();
        logic ov, ir, ex;
        logic [31:0] pv;
        int it;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 1; d <= 2; d++) begin
            sample(d, ov, ir, pv, it, ex);
            vectors++;
            if (ov !== 1'b0 || pv !== 32'd0 || it != 0 || ex !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs dut%0d: out_valid=%b p=%0d iters=%0d exact=%b, required 0/0/0/0",
                         d, ov, pv, it, ex);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 1; d <= 2; d++) begin
            sample(d, ov, ir, pv, it, ex);
            vectors++;
            if (ir !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_in_ready dut%0d: got %b, required 1", d, ir);
            end
        end
    endtask

    // Fixed vectors: {dut, a, b, p, iters, exact, latency}.
    task automatic test_fixed_vectors();
        int          dsel [5] = '{2, 1, 2, 2, 2};
        logic [15:0] av   [5] = '{16'd12, 16'd12, 16'd0,  16'd16, 16'd65535};
        logic [15:0] bv   [5] = '{16'd10, 16'd10, 16'd55, 16'd8,  16'd65535};
        logic [31:0] pe   [5] = '{32'd120, 32'd112, 32'd0, 32'd128, 32'd4026433536};
        int          ie   [5] = '{2, 1, 0, 1, 2};
        logic        xe   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int          le   [5] = '{8, 4, 1, 5, 8};
        logic [31:0] pv;
        int it, lat;
        logic ex;
        bit to;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{p: pe[i], iters: ie[i], exact: xe[i], lat: le[i]});
            run_op(dsel[i], av[i], bv[i], pv, it, ex, lat, to);
            e = sb.pop_front();
            vectors++;
            if (to) begin
                miscompares++;
                $display("FAIL fixed%0d_timeout: no out_valid within 200 cycles, required after %0d", i, e.lat);
            end else if (pv !== e.p || it != e.iters || ex !== e.exact || lat != e.lat) begin
                miscompares++;
                $display("FAIL fixed%0d a=%0d b=%0d: p=%0d iters=%0d exact=%b lat=%0d, required p=%0d iters=%0d exact=%b lat=%0d",
                         i, av[i], bv[i], pv, it, ex, lat, e.p, e.iters, e.exact, e.lat);
            end
            $display("fixed%0d dut%0d a=%0d b=%0d -> p=%0d iters=%0d exact=%b lat=%0d",
                     i, dsel[i], av[i], bv[i], pv, it, ex, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a, b;
        logic [31:0] pv, pv2;
        int it, it2, lat;
        logic ex, ex2, ov, ir;
        bit to;
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            if (i % 6 == 1) a = N'(1) << $urandom_range(N - 1);
            if (i % 6 == 3) b = '0;
            if (i % 6 == 4) b = N'(3) << $urandom_range(N - 2);
            sb.push_back(model((i % 2 == 0) ? 2 : 1, a, b));
            run_op((i % 2 == 0) ? 2 : 1, a, b, pv, it, ex, lat, to);
            e = sb.pop_front();
            vectors++;
            if (to || pv !== e.p || it != e.iters || ex !== e.exact || lat != e.lat) begin
                miscompares++;
                $display("FAIL b2b%0d a=%0d b=%0d: p=%0d iters=%0d exact=%b lat=%0d timeout=%0d, required p=%0d iters=%0d exact=%b lat=%0d",
                         i, a, b, pv, it, ex, lat, to, e.p, e.iters, e.exact, e.lat);
            end
            sample((i % 2 == 0) ? 2 : 1, ov, ir, pv2, it2, ex2);
            vectors++;
            if (ov !== 1'b0 || ir !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b%0d_handshake: out_valid=%b in_ready=%b, required 0/1", i, ov, ir);
            end
            $display("b2b%0d a=%0d b=%0d -> p=%0d iters=%0d exact=%b lat=%0d", i, a, b, pv, it, ex, lat);
        end
    endtask

    task automatic test_backpressure_reset();
        logic ov, ir, ex;
        logic [31:0] pv;
        int it, n;
        exp_t e;
        sb.push_back('{p: 32'd120, iters: 2, exact: 1'b1, lat: 8});
        @(negedge clk);
        drive(2, 1'b1, 16'd12, 16'd10);
        @(negedge clk);
        drive(2, 1'b0, '0, '0);
        n = 0;
        sample(2, ov, ir, pv, it, ex);
        while (!ov && n < 200) begin
            @(negedge clk); n++;
            sample(2, ov, ir, pv, it, ex);
        end
        e = sb.pop_front();
        for (int c = 0; c < 10; c++) begin
            drive(2, 1'b1, 16'd3, 16'd5);
            @(negedge clk);
            sample(2, ov, ir, pv, it, ex);
            vectors++;
            if (ov !== 1'b1 || ir !== 1'b0 || pv !== e.p || it != e.iters || ex !== e.exact) begin
                miscompares++;
                $display("FAIL stall%0d: out_valid=%b in_ready=%b p=%0d iters=%0d exact=%b, required 1/0/%0d/%0d/%b",
                         c, ov, ir, pv, it, ex, e.p, e.iters, e.exact);
            end
        end
        drive(2, 1'b0, '0, '0);
        set_ready(2, 1'b1);
        @(negedge clk);
        set_ready(2, 1'b0);
        sample(2, ov, ir, pv, it, ex);
        vectors++;
        if (ov !== 1'b0 || ir !== 1'b1 || pv !== 32'd120) begin
            miscompares++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b p=%0d, required 0/1/120", ov, ir, pv);
        end
        $display("stall: held p=%0d for 10 cycles, released", pv);
        // New operation; the reset lands while the controller sits in ADD1.
        drive(2, 1'b1, 16'd100, 16'd7);
        @(negedge clk);
        drive(2, 1'b0, '0, '0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        sample(2, ov, ir, pv, it, ex);
        vectors++;
        if (ov !== 1'b0 || pv !== 32'd0 || it != 0 || ex !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset: out_valid=%b p=%0d iters=%0d exact=%b, required 0/0/0/0", ov, pv, it, ex);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sample(2, ov, ir, pv, it, ex);
        vectors++;
        if (ir !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_reset_in_ready: got %b, required 1", ir);
        end
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            sample(2, ov, ir, pv, it, ex);
            if (ov) n++;
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL midop_reset_no_result: out_valid seen %0d cycles, required 0", n);
        end
        $display("midop reset: discarded operation, in_ready=%b", ir);
    endtask

    initial begin
        drive(1, 1'b0, '0, '0);
        drive(2, 1'b0, '0, '0);
        set_ready(1, 1'b0);
        set_ready(2, 1'b0);
        test_reset();
        test_fixed_vectors();
        test_back_to_back();
        test_backpressure_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
